// File: rtl/alu_pkg.sv
// Shared ALU-control definitions: ALU codes, ALU-op classes and stage FSM states.
// Used by the alu_ctrl_stage slice; optional illegal-op flag is ALU_CTRL_ILLEGAL_EN.
package alu_pkg;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_XOR  = 3'b011;
  localparam logic [2:0] ALU_NOR  = 3'b100;
  localparam logic [2:0] ALU_SRL  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLTU = 3'b111;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StTwo
  } state_e;

endpackage

// File: rtl/alu_ctrl_stage_if.sv
// Handshake bundle for alu_ctrl_stage: decoded fields in, ALU code out, plus flush.
// out_illegal exists only when ALU_CTRL_ILLEGAL_EN is defined.
interface alu_ctrl_stage_if #(
  parameter int unsigned TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_alu_op;
  logic [2:0]       in_funct3;
  logic             in_funct7_5;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       out_alu_operation;
  logic [TAG_W-1:0] out_tag;
`ifdef ALU_CTRL_ILLEGAL_EN
  logic             out_illegal;
`endif

  // master: the environment around the stage (upstream + execute)
  modport master (
    output in_valid, in_alu_op, in_funct3, in_funct7_5, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_alu_operation, out_tag
`ifdef ALU_CTRL_ILLEGAL_EN
    , input out_illegal
`endif
  );

  // slave: the alu_ctrl_stage itself
  modport slave (
    input  in_valid, in_alu_op, in_funct3, in_funct7_5, in_tag, flush, out_ready,
    output in_ready, out_valid, out_alu_operation, out_tag
`ifdef ALU_CTRL_ILLEGAL_EN
    , output out_illegal
`endif
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational map from {ALU-op class, funct3, funct7_5} to the 3-bit ALU code.
// Illegal encodings fall back to add; the flag is exported only under ALU_CTRL_ILLEGAL_EN.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_5,
  output logic [2:0] o_alu_operation
`ifdef ALU_CTRL_ILLEGAL_EN
  ,
  output logic       o_illegal
`endif
);

  logic [2:0] w_code;
  logic       w_illegal;

  always_comb begin
    w_code    = ALU_ADD;
    w_illegal = 1'b0;
    case (i_alu_op)
      ALUOP_MEM: w_code = ALU_ADD;
      ALUOP_BR: begin
        case (i_funct3)
          3'b000, 3'b001: w_code = ALU_SUB;
          3'b110, 3'b111: w_code = ALU_SLTU;
          default:        w_illegal = 1'b1;
        endcase
      end
      default: begin
        // R-type and I-type share the map; only R-type honours funct7_5 for sub
        case (i_funct3)
          3'b000:  w_code = (i_alu_op == ALUOP_R && i_funct7_5) ? ALU_SUB : ALU_ADD;
          3'b111:  w_code = ALU_AND;
          3'b110:  w_code = ALU_OR;
          3'b100:  w_code = ALU_XOR;
          3'b011:  w_code = ALU_SLTU;
          3'b101: begin
            if (i_funct7_5) w_illegal = 1'b1;
            else            w_code    = ALU_SRL;
          end
          default: w_illegal = 1'b1;
        endcase
      end
    endcase
  end

  assign o_alu_operation = w_illegal ? ALU_ADD : w_code;
`ifdef ALU_CTRL_ILLEGAL_EN
  assign o_illegal = w_illegal;
`endif

endmodule

// File: rtl/alu_ctrl_stage.sv
// Registered ALU-control stage: decode on input, two-entry skid buffer on output, flush.
// Define ALU_CTRL_ILLEGAL_EN to carry a per-entry illegal-op flag to out_illegal.
module alu_ctrl_stage
  import alu_pkg::*;
#(
  parameter int unsigned TAG_W = 32
) (
  input logic           clk,
  input logic           rst_n,
  alu_ctrl_stage_if.slave bus
);

  logic [2:0] w_dec_op;
`ifdef ALU_CTRL_ILLEGAL_EN
  logic       w_dec_illegal;
  logic       r_out_illegal;
  logic       r_skid_illegal;
`endif

  alu_ctrl_decode u_decode (
    .i_alu_op        (bus.in_alu_op),
    .i_funct3        (bus.in_funct3),
    .i_funct7_5      (bus.in_funct7_5),
    .o_alu_operation (w_dec_op)
`ifdef ALU_CTRL_ILLEGAL_EN
    ,
    .o_illegal       (w_dec_illegal)
`endif
  );

  state_e           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [2:0]       r_out_op;
  logic [TAG_W-1:0] r_out_tag;
  logic [2:0]       r_skid_op;
  logic [TAG_W-1:0] r_skid_tag;

  logic w_accept;
  logic w_drain;

  assign w_accept = bus.in_valid && r_in_ready;
  assign w_drain  = r_out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= StEmpty;
      r_in_ready     <= 1'b1;
      r_out_valid    <= 1'b0;
      r_out_op       <= ALU_ADD;
      r_out_tag      <= '0;
      r_skid_op      <= ALU_ADD;
      r_skid_tag     <= '0;
`ifdef ALU_CTRL_ILLEGAL_EN
      r_out_illegal  <= 1'b0;
      r_skid_illegal <= 1'b0;
`endif
    end else if (bus.flush) begin
      // flush wins over accept and drain; stale payload is harmless once invalid
      r_state     <= StEmpty;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StEmpty: begin
          if (w_accept) begin
            r_state     <= StOne;
            r_out_valid <= 1'b1;
            r_out_op    <= w_dec_op;
            r_out_tag   <= bus.in_tag;
`ifdef ALU_CTRL_ILLEGAL_EN
            r_out_illegal <= w_dec_illegal;
`endif
          end
        end
        StOne: begin
          if (w_accept && !w_drain) begin
            r_state    <= StTwo;
            r_in_ready <= 1'b0;
            r_skid_op  <= w_dec_op;
            r_skid_tag <= bus.in_tag;
`ifdef ALU_CTRL_ILLEGAL_EN
            r_skid_illegal <= w_dec_illegal;
`endif
          end else if (!w_accept && w_drain) begin
            r_state     <= StEmpty;
            r_out_valid <= 1'b0;
          end else if (w_accept && w_drain) begin
            r_out_op  <= w_dec_op;
            r_out_tag <= bus.in_tag;
`ifdef ALU_CTRL_ILLEGAL_EN
            r_out_illegal <= w_dec_illegal;
`endif
          end
        end
        StTwo: begin
          if (w_drain) begin
            r_state    <= StOne;
            r_in_ready <= 1'b1;
            r_out_op   <= r_skid_op;
            r_out_tag  <= r_skid_tag;
`ifdef ALU_CTRL_ILLEGAL_EN
            r_out_illegal <= r_skid_illegal;
`endif
          end
        end
        default: begin
          r_state     <= StEmpty;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready          = r_in_ready;
  assign bus.out_valid         = r_out_valid;
  assign bus.out_alu_operation = r_out_op;
  assign bus.out_tag           = r_out_tag;
`ifdef ALU_CTRL_ILLEGAL_EN
  assign bus.out_illegal       = r_out_illegal;
`endif

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Directed self-checking bench for alu_ctrl_stage; checks out_illegal when
// ALU_CTRL_ILLEGAL_EN is defined.
module tb_alu_ctrl_stage;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  alu_ctrl_stage_if #(.TAG_W(32)) bus ();

  alu_ctrl_stage #(.TAG_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference decode, returns {illegal, code}
  function automatic logic [3:0] ref_dec(input logic [1:0] op, input logic [2:0] f3,
                                         input logic f7);
    logic [3:0] r;
    r = {1'b0, 3'b010};
    if (op == 2'b00) r = {1'b0, 3'b010};
    else if (op == 2'b01) begin
      if (f3 == 3'b000 || f3 == 3'b001)      r = {1'b0, 3'b110};
      else if (f3 == 3'b110 || f3 == 3'b111) r = {1'b0, 3'b111};
      else                                   r = {1'b1, 3'b010};
    end else begin
      if (f3 == 3'b000)      r = (op == 2'b10 && f7) ? {1'b0, 3'b110} : {1'b0, 3'b010};
      else if (f3 == 3'b111) r = {1'b0, 3'b000};
      else if (f3 == 3'b110) r = {1'b0, 3'b001};
      else if (f3 == 3'b100) r = {1'b0, 3'b011};
      else if (f3 == 3'b011) r = {1'b0, 3'b111};
      else if (f3 == 3'b101) r = f7 ? {1'b1, 3'b010} : {1'b0, 3'b101};
      else                   r = {1'b1, 3'b010};
    end
    return r;
  endfunction

  task automatic idle_inputs();
    bus.in_valid    = 1'b0;
    bus.in_alu_op   = 2'b00;
    bus.in_funct3   = 3'b000;
    bus.in_funct7_5 = 1'b0;
    bus.in_tag      = '0;
    bus.flush       = 1'b0;
    bus.out_ready   = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
    else n_pass++;
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    else n_pass++;
    n_checks++;
    if (bus.out_alu_operation !== 3'b010)
      $display("FAIL reset_alu_op got %b want 010", bus.out_alu_operation);
    else n_pass++;
    n_checks++;
    if (bus.out_tag !== 32'd0) $display("FAIL reset_tag got %0d want 0", bus.out_tag);
    else n_pass++;
`ifdef ALU_CTRL_ILLEGAL_EN
    n_checks++;
    if (bus.out_illegal !== 1'b0) $display("FAIL reset_illegal got %b want 0", bus.out_illegal);
    else n_pass++;
`endif
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_decode_vectors();
    logic [1:0] v_op  [4] = '{2'b10, 2'b01, 2'b10, 2'b11};
    logic [2:0] v_f3  [4] = '{3'b000, 3'b110, 3'b101, 3'b000};
    logic       v_f7  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [2:0] v_exp [4] = '{3'b110, 3'b111, 3'b010, 3'b010};
    logic       v_ill [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.in_valid    = 1'b1;
      bus.in_alu_op   = v_op[k];
      bus.in_funct3   = v_f3[k];
      bus.in_funct7_5 = v_f7[k];
      bus.in_tag      = 32'd500 + k;
      cycle();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_alu_operation !== v_exp[k])
        $display("FAIL vec%0d_code got v=%b op=%b want v=1 op=%b", k, bus.out_valid,
                 bus.out_alu_operation, v_exp[k]);
      else n_pass++;
`ifdef ALU_CTRL_ILLEGAL_EN
      n_checks++;
      if (bus.out_illegal !== v_ill[k])
        $display("FAIL vec%0d_illegal got %b want %b", k, bus.out_illegal, v_ill[k]);
      else n_pass++;
`else
      if (v_ill[k] === 1'bx) $display("unexpected vector table entry");
`endif
    end
    bus.in_valid = 1'b0;
    cycle();
  endtask

  task automatic test_decode_sweep();
    logic [5:0] v;
    logic [3:0] e;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      v = i[5:0];
      bus.in_valid    = 1'b1;
      bus.in_alu_op   = v[5:4];
      bus.in_funct3   = v[3:1];
      bus.in_funct7_5 = v[0];
      bus.in_tag      = 32'd100 + i;
      e = ref_dec(v[5:4], v[3:1], v[0]);
      cycle();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_alu_operation !== e[2:0] ||
          bus.out_tag !== 32'd100 + i)
        $display("FAIL sweep%0d got v=%b op=%b tag=%0d want v=1 op=%b tag=%0d", i,
                 bus.out_valid, bus.out_alu_operation, bus.out_tag, e[2:0], 100 + i);
      else n_pass++;
`ifdef ALU_CTRL_ILLEGAL_EN
      n_checks++;
      if (bus.out_illegal !== e[3])
        $display("FAIL sweep%0d_illegal got %b want %b", i, bus.out_illegal, e[3]);
      else n_pass++;
`endif
    end
    bus.in_valid = 1'b0;
    cycle();
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL sweep_drain got %b want 0", bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    bus.in_alu_op = 2'b00;
    bus.in_valid  = 1'b1;
    bus.in_tag    = 32'd1;
    cycle();
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL bp_ready_after1 got %b want 1", bus.in_ready);
    else n_pass++;
    bus.in_tag = 32'd2;
    cycle();
    n_checks++;
    if (bus.in_ready !== 1'b0) $display("FAIL bp_ready_after2 got %b want 0", bus.in_ready);
    else n_pass++;
    bus.in_tag = 32'd3;
    repeat (3) cycle();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_tag !== 32'd1)
      $display("FAIL bp_hold got v=%b tag=%0d want v=1 tag=1", bus.out_valid, bus.out_tag);
    else n_pass++;
    bus.out_ready = 1'b1;
    cycle();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_tag !== 32'd2)
      $display("FAIL bp_out2 got v=%b tag=%0d want v=1 tag=2", bus.out_valid, bus.out_tag);
    else n_pass++;
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL bp_ready_reopen got %b want 1", bus.in_ready);
    else n_pass++;
    cycle();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_tag !== 32'd3)
      $display("FAIL bp_out3 got v=%b tag=%0d want v=1 tag=3", bus.out_valid, bus.out_tag);
    else n_pass++;
    cycle();
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL bp_empty got %b want 0", bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int bad;
    bad = 0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bus.in_alu_op = 2'b11;
      bus.in_funct3 = (i % 2 == 0) ? 3'b111 : 3'b100;
      bus.in_tag    = 32'd1000 + i;
      cycle();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 || bus.out_tag !== 32'd1000 + i ||
          bus.out_alu_operation !== ((i % 2 == 0) ? 3'b000 : 3'b011))
        $display("FAIL b2b%0d got v=%b rdy=%b tag=%0d op=%b want v=1 rdy=1 tag=%0d", i,
                 bus.out_valid, bus.in_ready, bus.out_tag, bus.out_alu_operation, 1000 + i);
      else n_pass++;
    end
    bus.in_valid  = 1'b0;
    bus.in_funct3 = 3'b000;
    cycle();
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_tag    = 32'd7;
    cycle();
    bus.in_tag = 32'd8;
    cycle();
    n_checks++;
    if (bus.in_ready !== 1'b0) $display("FAIL flush_setup_two got %b want 0", bus.in_ready);
    else n_pass++;
    bus.in_tag = 32'd9;
    bus.flush  = 1'b1;
    cycle();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL flush_two got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready);
    else n_pass++;
    bus.out_ready = 1'b1;
    repeat (3) cycle();
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL flush_stays_empty got %b want 0", bus.out_valid);
    else n_pass++;
    // beat offered with in_ready=1 during flush must also be dropped
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_tag    = 32'd10;
    bus.flush     = 1'b1;
    cycle();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL flush_drop_ready got %b want 0", bus.out_valid);
    else n_pass++;
    cycle();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL flush_after got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    bus.out_ready   = 1'b0;
    bus.in_valid    = 1'b1;
    bus.in_alu_op   = 2'b10;
    bus.in_funct3   = 3'b110;
    bus.in_tag      = 32'd42;
    cycle();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_tag !== 32'd42 || bus.out_alu_operation !== 3'b001)
      $display("FAIL arst_setup got v=%b tag=%0d op=%b want v=1 tag=42 op=001",
               bus.out_valid, bus.out_tag, bus.out_alu_operation);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL arst_valid got %b want 0", bus.out_valid);
    else n_pass++;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_alu_operation !== 3'b010 || bus.out_tag !== 32'd0)
      $display("FAIL arst_outs got rdy=%b op=%b tag=%0d want rdy=1 op=010 tag=0",
               bus.in_ready, bus.out_alu_operation, bus.out_tag);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    idle_inputs();
    test_reset();
    test_decode_vectors();
    test_decode_sweep();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_stage.md
# alu_ctrl_stage

Registered ALU-control stage that produces the 3-bit `ALU_operation` code consumed by the datapath ALU. It sits between instruction decode and execute. It accepts decoded instruction fields over a valid/ready handshake, maps them to the ALU encoding, and presents the result through a two-entry skid buffer, so there are no bubbles and no combinational ready path. It also supports a pipeline flush.

## Interface
- `TAG_W`, 32: width of the opaque side-band tag (PC or rd index) carried alongside each op.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream has a decoded instruction.
- `in_ready`  out  1  stage can accept; registered.
- `in_alu_op`  in  2  class: 00 mem/auipc, 01 branch, 10 R-type, 11 I-type ALU.
- `in_funct3`  in  3  instruction funct3.
- `in_funct7_5`  in  1  instruction bit 30.
- `in_tag`  in  TAG_W  side-band, passed unchanged.
- `flush`  in  1  discard all held and incoming entries this cycle.
- `out_valid`  out  1  `out_*` holds a valid op.
- `out_ready`  in  1  execute stage accepts.
- `out_alu_operation`  out  3  ALU code: and 000, or 001, add 010, xor 011, nor 100, srl 101, sub 110, sltu 111.
- `out_tag`  out  TAG_W  tag of presented op.
- `out_illegal`  out  1  op unsupported by the ALU (present only under the macro).

## Operation
- Decode map:
  - `in_alu_op`=00 → add.
  - 01 → funct3 000/001 → sub; 110/111 → sltu; others illegal.
  - 10 → funct3 000 → add, or sub when funct7_5=1; 111 and; 110 or; 100 xor; 011 sltu; 101 → srl when funct7_5=0, illegal when 1; 001/010 illegal.
  - 11 → same as 10, except funct3 000 is always add.
  - nor is never generated.
- The illegal encoding substitutes add (010).
- Transfer in when `in_valid && in_ready`. Transfer out when `out_valid && out_ready`.
- FSM over {EMPTY, ONE, TWO}. Main register drives `out_*`; skid register holds the overflow entry.
  - EMPTY: accept → ONE.
  - ONE:
    - accept without drain → TWO (new entry to skid);
    - drain without accept → EMPTY;
    - both → ONE (main replaced).
  - TWO: `in_ready`=0; drain → ONE (skid moves to main).
- `in_ready` = (next state ≠ TWO), registered.
- Ordering is strictly FIFO; tags never reorder.
- `flush`: next state EMPTY and `out_valid`=0 next cycle. The input beat offered in the same cycle is dropped, even if `in_ready`=1. Flush has priority over accept and drain.

## Timing
- Latency: accept in cycle N → `out_valid` in cycle N+1.
- Throughput: 1 op/cycle sustained while `out_ready`=1.
- Reset values: `out_valid`=0, `in_ready`=1, `out_alu_operation`=010, `out_tag`=0, `out_illegal`=0, state EMPTY.
- Reset asserted mid-operation drops all entries immediately, asynchronously.
- `out_*` hold stable while `out_valid && !out_ready`.
- `in_ready` falls the cycle after the second entry is captured. No input beat is lost, because the skid absorbs the beat accepted while ready was high.
- All outputs are registered; no input-to-output combinational path.

## Configuration
- `ALU_CTRL_ILLEGAL_EN` defined:
  - `out_illegal` port exists and is stored per entry in both registers.
  - It is 1 exactly for the illegal encodings above, with `out_alu_operation`=010.
- Undefined:
  - port and storage removed;
  - illegal encodings silently map to add.

## Structure
- Shared package `alu_pkg`: ALU code constants (ALU_AND … ALU_SLTU), ALU-op class constants (ALUOP_MEM/BR/R/I), FSM state typedef.
- One combinational sub-module `alu_ctrl_decode` (class/funct3/funct7_5 → code and illegal). It is instantiated once on the input side; only decoded results are stored.

## Test plan
- Reset: hold `rst_n`=0 → `out_valid`=0, `in_ready`=1, `out_alu_operation`=010.
- Decode sweep: all 64 {alu_op, funct3, funct7_5} combinations with `out_ready`=1 → each code appears one cycle later. Example: {10,000,1} → 110; {01,110,x} → 111; {10,101,1} → 010 with illegal=1 under the macro.
- Backpressure: stream tags 1,2,3 with `out_ready`=0 → `in_ready` drops after tag 2. Release `out_ready` → tags emerge 1,2,3 on consecutive cycles, none lost.
- Full throughput: 100 back-to-back ops with `out_ready`=1 → 100 outputs in 100 consecutive cycles, in order.
- Flush in state TWO with `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1; the offered beat never appears.
- Async reset asserted mid-stream in state ONE → `out_valid` low without waiting for a clock edge.
